axi4_slave_wrapper: RTL and testbench

AXI4 responder that sits opposite the operand-writing AXI4 master: it accepts 4-beat byte-wide write bursts carrying operands a and b, commits them to internal registers, forms the 2*SZ-bit product, and serves byte-wide read bursts of operands and product. It is the slave end of the same AW/W/B/AR/R channel set, sharing the same single-bit "1 => ok" response convention, and is clocked from the master's `out_clk`.

---
 rtl/axi4_pkg.sv | 27 ++
 rtl/axi4_slave_wrapper_if.sv | 33 +++
 rtl/axi4_slave_regfile.sv | 55 +++++
 rtl/axi4_slave_wrapper.sv | 185 ++++++++++++++++++
 tb/tb_axi4_slave_wrapper.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi4_pkg.sv
// Shared constants, address map and FSM state types for the AXI4 operand/product slave.
package axi4_pkg;

    localparam int SZ    = 32;
    localparam int ASZ   = 2;
    localparam int DSZ   = 8;
    localparam int BEATS = SZ / DSZ;
    localparam int BIW   = $clog2(BEATS);
    localparam int CNTW  = $clog2(BEATS + 1);

    localparam logic [ASZ-1:0] ADDR_A      = 2'd0;
    localparam logic [ASZ-1:0] ADDR_B      = 2'd1;
    localparam logic [ASZ-1:0] ADDR_RES_LO = 2'd2;
    localparam logic [ASZ-1:0] ADDR_RES_HI = 2'd3;

    localparam logic RESP_OK  = 1'b1;
    localparam logic RESP_ERR = 1'b0;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_COMMIT, W_RESP} wstate_e;
    typedef enum logic       {R_IDLE, R_DATA} rstate_e;

    // Byte idx of a word, least significant byte first.
    function automatic logic [DSZ-1:0] byte_of(input logic [SZ-1:0] w, input logic [BIW-1:0] idx);
        return w[idx*DSZ +: DSZ];
    endfunction

endpackage

// File: rtl/axi4_slave_wrapper_if.sv
// AW/W/B/AR/R channel bundle between the operand-writing master and this slave.
interface axi4_slave_wrapper_if;

    logic [axi4_pkg::ASZ-1:0] awaddr;
    logic                     awvalid;
    logic                     awready;
    logic [axi4_pkg::DSZ-1:0] wdata;
    logic                     wvalid;
    logic                     wready;
    logic                     wlast;
    logic                     bresp;
    logic                     bvalid;
    logic                     bready;
    logic [axi4_pkg::ASZ-1:0] araddr;
    logic                     arvalid;
    logic                     arready;
    logic [axi4_pkg::DSZ-1:0] rdata;
    logic                     rvalid;
    logic                     rready;
    logic                     rlast;
    logic                     rresp;

    modport slave (
        input  awaddr, awvalid, wdata, wvalid, wlast, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rvalid, rlast, rresp
    );

    modport master (
        output awaddr, awvalid, wdata, wvalid, wlast, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rvalid, rlast, rresp
    );

endinterface

// File: rtl/axi4_slave_regfile.sv
// Committed operands a/b, the registered full-width product, and a byte read port.
module axi4_slave_regfile
    import axi4_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              commit_en_i,
    input  logic              commit_sel_i,
    input  logic [SZ-1:0]     commit_data_i,
    input  logic [ASZ-1:0]    rd_word_i,
    input  logic [BIW-1:0]    rd_byte_i,
    output logic [DSZ-1:0]    rd_data_o,
    output logic [SZ-1:0]     a_o,
    output logic [SZ-1:0]     b_o,
    output logic [2*SZ-1:0]   res_o
);

    logic [SZ-1:0]   a_q;
    logic [SZ-1:0]   b_q;
    logic [2*SZ-1:0] res_q;
    logic [SZ-1:0]   rd_word_d;

    // Operand commit and free-running product, so res follows a commit by one cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_q   <= '0;
            b_q   <= '0;
            res_q <= '0;
        end else begin
            if (commit_en_i) begin
                if (commit_sel_i) b_q <= commit_data_i;
                else              a_q <= commit_data_i;
            end
            res_q <= (2*SZ)'(a_q) * (2*SZ)'(b_q);
        end
    end

    // Word select over the address map, then pick the requested byte.
    always_comb begin
        rd_word_d = a_q;
        case (rd_word_i)
            ADDR_A:      rd_word_d = a_q;
            ADDR_B:      rd_word_d = b_q;
            ADDR_RES_LO: rd_word_d = res_q[SZ-1:0];
            ADDR_RES_HI: rd_word_d = res_q[2*SZ-1:SZ];
            default:     rd_word_d = a_q;
        endcase
        rd_data_o = byte_of(rd_word_d, rd_byte_i);
    end

    assign a_o   = a_q;
    assign b_o   = b_q;
    assign res_o = res_q;

endmodule

// File: rtl/axi4_slave_wrapper.sv
// AXI4 slave: byte-wide 4-beat write bursts commit operands, read bursts return operands/product.
module axi4_slave_wrapper
    import axi4_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_ni,
    axi4_slave_wrapper_if.slave bus,
    output logic [SZ-1:0]       a_o,
    output logic [SZ-1:0]       b_o,
    output logic [2*SZ-1:0]     res_o
);

    wstate_e           wstate_q;
    logic [ASZ-1:0]    awaddr_q;
    logic [CNTW-1:0]   cnt_q;
    logic              err_q;
    logic [DSZ-1:0]    shadow_q [BEATS];
    logic              awready_q;
    logic              wready_q;
    logic              bvalid_q;
    logic              bresp_q;

    rstate_e           rstate_q;
    logic [ASZ-1:0]    araddr_q;
    logic [BIW-1:0]    rbeat_q;
    logic              arready_q;
    logic              rvalid_q;
    logic [DSZ-1:0]    rdata_q;
    logic              rlast_q;
    logic              rresp_q;

    logic              writable;
    logic              commit_en;
    logic [SZ-1:0]     commit_data;
    logic [ASZ-1:0]    rd_word;
    logic [BIW-1:0]    rd_byte;
    logic [DSZ-1:0]    rd_data;

    assign writable  = (awaddr_q == ADDR_A) || (awaddr_q == ADDR_B);
    assign commit_en = (wstate_q == W_COMMIT) && !err_q && writable;

    // Shadow buffer flattened into a word, byte 0 in the least significant position.
    always_comb begin
        commit_data = '0;
        for (int k = 0; k < BEATS; k++) begin
            commit_data[k*DSZ +: DSZ] = shadow_q[k];
        end
    end

    // Byte 0 of the newly addressed word is fetched while idle; otherwise the next byte.
    always_comb begin
        rd_word = araddr_q;
        rd_byte = rbeat_q + 1'b1;
        if (rstate_q == R_IDLE) begin
            rd_word = bus.araddr;
            rd_byte = '0;
        end
    end

    axi4_slave_regfile u_regfile (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .commit_en_i   (commit_en),
        .commit_sel_i  (awaddr_q[0]),
        .commit_data_i (commit_data),
        .rd_word_i     (rd_word),
        .rd_byte_i     (rd_byte),
        .rd_data_o     (rd_data),
        .a_o           (a_o),
        .b_o           (b_o),
        .res_o         (res_o)
    );

    // Write FSM: collect beats into the shadow buffer, commit once, then respond.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wstate_q  <= W_IDLE;
            awaddr_q  <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            shadow_q  <= '{default: '0};
            awready_q <= 1'b1;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 1'b0;
        end else begin
            case (wstate_q)
                W_IDLE: begin
                    if (bus.awvalid && awready_q) begin
                        awaddr_q  <= bus.awaddr;
                        cnt_q     <= '0;
                        err_q     <= 1'b0;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b1;
                        wstate_q  <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (bus.wvalid && wready_q) begin
                        if (cnt_q < CNTW'(BEATS)) begin
                            shadow_q[cnt_q[BIW-1:0]] <= bus.wdata;
                            cnt_q <= cnt_q + 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                        if (bus.wlast) begin
                            if (cnt_q != CNTW'(BEATS - 1)) err_q <= 1'b1;
                            wready_q <= 1'b0;
                            wstate_q <= W_COMMIT;
                        end
                    end
                end
                W_COMMIT: begin
                    wstate_q <= W_RESP;
                end
                W_RESP: begin
                    if (!bvalid_q) begin
                        bvalid_q <= 1'b1;
                        bresp_q  <= (!err_q && writable) ? RESP_OK : RESP_ERR;
                    end else if (bus.bready) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        wstate_q  <= W_IDLE;
                    end
                end
                default: wstate_q <= W_IDLE;
            endcase
        end
    end

    // Read FSM: each beat is sampled from the committed registers when it loads.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rstate_q  <= R_IDLE;
            araddr_q  <= '0;
            rbeat_q   <= '0;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rlast_q   <= 1'b0;
            rresp_q   <= 1'b0;
        end else begin
            case (rstate_q)
                R_IDLE: begin
                    if (bus.arvalid && arready_q) begin
                        araddr_q  <= bus.araddr;
                        rbeat_q   <= '0;
                        rdata_q   <= rd_data;
                        rvalid_q  <= 1'b1;
                        rresp_q   <= RESP_OK;
                        rlast_q   <= (BEATS == 1);
                        arready_q <= 1'b0;
                        rstate_q  <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (bus.rready) begin
                        if (rlast_q) begin
                            rvalid_q  <= 1'b0;
                            rlast_q   <= 1'b0;
                            arready_q <= 1'b1;
                            rstate_q  <= R_IDLE;
                        end else begin
                            rbeat_q <= rd_byte;
                            rdata_q <= rd_data;
                            rlast_q <= (rd_byte == BIW'(BEATS - 1));
                        end
                    end
                end
                default: rstate_q <= R_IDLE;
            endcase
        end
    end

    assign bus.awready = awready_q;
    assign bus.wready  = wready_q;
    assign bus.bvalid  = bvalid_q;
    assign bus.bresp   = bresp_q;
    assign bus.arready = arready_q;
    assign bus.rvalid  = rvalid_q;
    assign bus.rdata   = rdata_q;
    assign bus.rlast   = rlast_q;
    assign bus.rresp   = rresp_q;

endmodule

// File: tb/tb_axi4_slave_wrapper.sv
// Directed and randomized bursts against a small operand/product model with scoreboards.
module tb_axi4_slave_wrapper;
    import axi4_pkg::*;

    localparam int BUDGET = 50;

    logic            clk = 1'b0;
    logic            rstN;
    logic [SZ-1:0]   aObs;
    logic [SZ-1:0]   bObs;
    logic [2*SZ-1:0] resObs;

    int compared   = 0;
    int mismatched = 0;

    logic [SZ-1:0]  modelA = '0;
    logic [SZ-1:0]  modelB = '0;
    logic           bQ[$];
    logic [DSZ-1:0] rQ[$];

    axi4_slave_wrapper_if bus();

    axi4_slave_wrapper dut (
        .clk_i  (clk),
        .rst_ni (rstN),
        .bus    (bus),
        .a_o    (aObs),
        .b_o    (bObs),
        .res_o  (resObs)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Hard stop in case a handshake never completes.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [2*SZ-1:0] observed,
                               input logic [2*SZ-1:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [SZ-1:0] modelWord(input logic [ASZ-1:0] addr);
        logic [2*SZ-1:0] p;
        p = (2*SZ)'(modelA) * (2*SZ)'(modelB);
        case (addr)
            2'd0:    return modelA;
            2'd1:    return modelB;
            2'd2:    return p[SZ-1:0];
            default: return p[2*SZ-1:SZ];
        endcase
    endfunction

    task automatic resetChecks();
        checkOutput("rst_awready", bus.awready, 1'b1);
        checkOutput("rst_wready",  bus.wready,  1'b0);
        checkOutput("rst_bvalid",  bus.bvalid,  1'b0);
        checkOutput("rst_bresp",   bus.bresp,   1'b0);
        checkOutput("rst_arready", bus.arready, 1'b1);
        checkOutput("rst_rvalid",  bus.rvalid,  1'b0);
        checkOutput("rst_rdata",   bus.rdata,   8'h00);
        checkOutput("rst_rlast",   bus.rlast,   1'b0);
        checkOutput("rst_rresp",   bus.rresp,   1'b0);
        checkOutput("rst_a",       aObs,        '0);
        checkOutput("rst_b",       bObs,        '0);
        checkOutput("rst_res",     resObs,      '0);
    endtask

    // Write burst: nBeats beats, wlast on lastBeat; abortBeat >= 0 asserts reset mid-beat.
    task automatic applyStimulus(input logic [ASZ-1:0] addr, input logic [SZ-1:0] word,
                                 input int nBeats, input int lastBeat, input bit gaps,
                                 input int abortBeat);
        logic expResp;
        logic exp;
        int   t;
        expResp = ((addr == ADDR_A) || (addr == ADDR_B)) && (nBeats == BEATS) && (lastBeat == BEATS - 1);
        if (abortBeat < 0) bQ.push_back(expResp);
        bus.awaddr  = addr;
        bus.awvalid = 1'b1;
        t = 0;
        while (bus.awready !== 1'b1 && t < BUDGET) begin nextCycle(); t++; end
        checkOutput("awready", bus.awready, 1'b1);
        nextCycle();
        bus.awvalid = 1'b0;
        for (int k = 0; k < nBeats; k++) begin
            if (gaps) begin
                int n;
                n = $urandom_range(0, 2);
                repeat (n) begin
                    nextCycle();
                    checkOutput("wready_stall", bus.wready, 1'b1);
                end
            end
            bus.wdata  = (k < BEATS) ? word[k*DSZ +: DSZ] : 8'hEE;
            bus.wlast  = (k == lastBeat);
            bus.wvalid = 1'b1;
            if (k == abortBeat) begin
                #2;
                rstN       = 1'b0;
                bus.wvalid = 1'b0;
                bus.wlast  = 1'b0;
                return;
            end
            t = 0;
            while (bus.wready !== 1'b1 && t < BUDGET) begin nextCycle(); t++; end
            checkOutput("wready", bus.wready, 1'b1);
            nextCycle();
            bus.wvalid = 1'b0;
            bus.wlast  = 1'b0;
        end
        t = 0;
        while (bus.bvalid !== 1'b1 && t < BUDGET) begin nextCycle(); t++; end
        checkOutput("bvalid", bus.bvalid, 1'b1);
        exp = bQ.pop_front();
        checkOutput("bresp", bus.bresp, exp);
        if (gaps) begin
            int n;
            n = $urandom_range(0, 2);
            repeat (n) begin
                nextCycle();
                checkOutput("bvalid_stall", bus.bvalid, 1'b1);
                checkOutput("bresp_stall", bus.bresp, exp);
            end
        end
        bus.bready = 1'b1;
        nextCycle();
        bus.bready = 1'b0;
        checkOutput("bvalid_clear", bus.bvalid, 1'b0);
        if (expResp) begin
            if (addr == ADDR_A) modelA = word;
            else                modelB = word;
        end
        checkOutput("a", aObs, modelA);
        checkOutput("b", bObs, modelB);
        checkOutput("res", resObs, (2*SZ)'(modelA) * (2*SZ)'(modelB));
    endtask

    // Read burst; mixed accepts either 8'h11 or 8'h22 per byte during a concurrent rewrite.
    task automatic readBurst(input logic [ASZ-1:0] addr, input bit stall, input bit mixed);
        logic [SZ-1:0]  w;
        logic [DSZ-1:0] exp;
        int             t;
        w = modelWord(addr);
        for (int k = 0; k < BEATS; k++) rQ.push_back(w[k*DSZ +: DSZ]);
        bus.araddr  = addr;
        bus.arvalid = 1'b1;
        t = 0;
        while (bus.arready !== 1'b1 && t < BUDGET) begin nextCycle(); t++; end
        checkOutput("arready", bus.arready, 1'b1);
        nextCycle();
        bus.arvalid = 1'b0;
        for (int k = 0; k < BEATS; k++) begin
            t = 0;
            while (bus.rvalid !== 1'b1 && t < BUDGET) begin nextCycle(); t++; end
            checkOutput("rvalid", bus.rvalid, 1'b1);
            exp = rQ.pop_front();
            if (mixed && bus.rdata === 8'h22) exp = 8'h22;
            checkOutput("rdata", bus.rdata, exp);
            checkOutput("rlast", bus.rlast, (k == BEATS - 1));
            checkOutput("rresp", bus.rresp, RESP_OK);
            if (stall) begin
                int n;
                n = $urandom_range(0, 3);
                repeat (n) begin
                    nextCycle();
                    checkOutput("rdata_stall", bus.rdata, exp);
                    checkOutput("rlast_stall", bus.rlast, (k == BEATS - 1));
                end
            end
            bus.rready = 1'b1;
            nextCycle();
            bus.rready = 1'b0;
        end
        checkOutput("rvalid_clear", bus.rvalid, 1'b0);
    endtask

    // Directed sequence followed by a randomized stretch, a concurrency case and a mid-burst reset.
    initial begin
        rstN        = 1'b0;
        bus.awaddr  = '0;
        bus.awvalid = 1'b0;
        bus.wdata   = '0;
        bus.wvalid  = 1'b0;
        bus.wlast   = 1'b0;
        bus.bready  = 1'b0;
        bus.araddr  = '0;
        bus.arvalid = 1'b0;
        bus.rready  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        resetChecks();
        @(negedge clk) rstN = 1'b1;
        nextCycle();

        $display("[TB] basic operand writes and product reads");
        applyStimulus(2'd0, 32'h12345678, 4, 3, 1'b0, -1);
        applyStimulus(2'd1, 32'h00000010, 4, 3, 1'b0, -1);
        checkOutput("plan_a", aObs, 64'h12345678);
        checkOutput("plan_b", bObs, 64'h10);
        checkOutput("plan_res", resObs, 64'h1_2345_6780);
        readBurst(2'd2, 1'b0, 1'b0);
        readBurst(2'd3, 1'b0, 1'b0);

        $display("[TB] write to read-only word");
        applyStimulus(2'd2, 32'hDDCCBBAA, 4, 3, 1'b0, -1);
        checkOutput("ro_res_keep", resObs, 64'h1_2345_6780);
        readBurst(2'd2, 1'b0, 1'b0);

        $display("[TB] malformed bursts");
        applyStimulus(2'd0, 32'hAABBCCDD, 2, 1, 1'b0, -1);
        checkOutput("short_a_keep", aObs, 64'h12345678);
        applyStimulus(2'd1, 32'h99999999, 5, 4, 1'b0, -1);
        checkOutput("long_b_keep", bObs, 64'h10);

        $display("[TB] randomized bursts with stalls");
        for (int i = 0; i < 20; i++) begin
            if ($urandom_range(0, 1) == 1)
                applyStimulus(ASZ'($urandom_range(0, 3)), $urandom, 4, 3, 1'b1, -1);
            else
                readBurst(ASZ'($urandom_range(0, 3)), 1'b1, 1'b0);
        end

        $display("[TB] read during write of the same word");
        applyStimulus(2'd0, 32'h11111111, 4, 3, 1'b0, -1);
        fork
            applyStimulus(2'd0, 32'h22222222, 4, 3, 1'b1, -1);
            begin
                repeat (2) nextCycle();
                readBurst(2'd0, 1'b0, 1'b1);
            end
        join
        readBurst(2'd0, 1'b0, 1'b0);

        $display("[TB] reset during third write beat");
        applyStimulus(2'd0, 32'h55555555, 4, 3, 1'b0, 2);
        #1;
        resetChecks();
        modelA = '0;
        modelB = '0;
        @(negedge clk) rstN = 1'b1;
        nextCycle();
        for (int w = 0; w < 4; w++) readBurst(ASZ'(w), 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
